esc_pwm_quad: RTL and testbench
===============================

ESC_PWM_QUAD -- requirements
Module: esc_pwm_quad

Interface
REQ-001 Parameter PERIOD, default 1000000: clock cycles per PWM frame (20 ms at 50 MHz).
REQ-002 Parameter MIN_PULSE, default 50000: pulse width in cycles for speed 0 (1 ms idle/arm pulse).
REQ-003 Parameter SPD_SHIFT, default 4: left shift applied to speed before adding to MIN_PULSE.
REQ-004 Parameter RAMP_STEP, default 64: maximum speed change per frame when ramping is compiled in.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wrt  input  1  one-cycle strobe; the four speed inputs are valid when it is high.
REQ-008 frnt_spd  input  11  unsigned front motor speed from the flight controller.
REQ-009 bck_spd  input  11  unsigned back motor speed.
REQ-010 lft_spd  input  11  unsigned left motor speed.
REQ-011 rght_spd  input  11  unsigned right motor speed.
REQ-012 frnt  output  1  registered PWM to front ESC.
REQ-013 bck  output  1  registered PWM to back ESC.
REQ-014 lft  output  1  registered PWM to left ESC.
REQ-015 rght  output  1  registered PWM to right ESC.
REQ-016 frm_strt  output  1  registered one-cycle pulse marking each frame start.

Function
REQ-017 Frame counter cnt SHALL count 0..PERIOD-1 and wrap to 0; width SHALL be ceil(log2(PERIOD)).
REQ-018 On wrt, all four speeds SHALL be captured into shadow registers in the same cycle; no wrt leaves the shadows unchanged.
REQ-019 In the load cycle (cnt==PERIOD-1), each active speed SHALL load from its shadow's current register value; a wrt in that same cycle updates the shadow only and takes effect in the following frame.
REQ-020 Active speeds SHALL NOT change at any cycle other than the load cycle.
REQ-021 Pulse width per channel SHALL be MIN_PULSE + (act_spd << SPD_SHIFT), computed unsigned, at least 20 bits wide, with no truncation.
REQ-022 Each PWM output SHALL be registered as (cnt < pulse width), so it is high for exactly pulse-width cycles per frame, starting one cycle after cnt==0.
REQ-023 frm_strt SHALL be registered as (cnt==PERIOD-1), so it is high in the cycle where cnt==0.
REQ-024 Speed 0 SHALL produce exactly MIN_PULSE high cycles and never a zero-width pulse.
REQ-025 Parameters SHALL satisfy MIN_PULSE + (2047 << SPD_SHIFT) < PERIOD; with defaults the maximum pulse is 82752 cycles.

Reset
REQ-026 While rst is high: cnt = PERIOD-1; shadows and active speeds = 0; frnt, bck, lft, rght and frm_strt = 0.
REQ-027 The first cycle after rst deasserts SHALL be a load cycle, giving frm_strt high and cnt==0 in the next cycle.
REQ-028 Reset asserted mid-frame SHALL drop all PWM outputs low on the next edge and discard pending shadow values.

Configuration
REQ-029 With macro ESC_RAMP_EN defined, each active speed at load SHALL move toward its shadow by min(|shadow-active|, RAMP_STEP), saturating exactly at the shadow value with no overshoot.
REQ-030 With ESC_RAMP_EN undefined, active speed SHALL equal the shadow directly at load and RAMP_STEP SHALL be unused.

Verification (bench parameters PERIOD=1000, MIN_PULSE=100, SPD_SHIFT=2, RAMP_STEP=64)
REQ-031 Release reset with all speeds 0 -> frm_strt pulses every 1000 cycles; each output is high for 100 cycles per frame.
REQ-032 wrt with frnt=10, bck=0, lft=2047, rght=100 mid-frame -> current frame unchanged; next frame pulses are 140, 100, 8288 (an invalid parameter set, so rerun with PERIOD=10000) and 500 cycles.
REQ-033 wrt in the exact load cycle with frnt=50 after an earlier frnt=20 -> next frame 180 cycles and the frame after 300 cycles.
REQ-034 Assert rst for one cycle during a 300-cycle pulse -> outputs go low the next edge; cnt restarts; pulses return to 100 cycles.
REQ-035 With ESC_RAMP_EN, step frnt 0->200 -> per-frame pulse widths are 356, 612, 868 and then 900 steady; step back to 0 decreases by 256 cycles per frame down to 100.

Source files
------------

// File: rtl/esc_pwm_quad.sv
// Four-channel ESC servo-style PWM generator with shadowed speed registers loaded once per frame.
// Optional per-frame speed ramping is compiled in with `define ESC_RAMP_EN.
module esc_pwm_quad #(
  parameter int unsigned PERIOD    = 1000000,
  parameter int unsigned MIN_PULSE = 50000,
  parameter int unsigned SPD_SHIFT = 4,
  parameter int unsigned RAMP_STEP = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [10:0] frnt_spd,
  input  logic [10:0] bck_spd,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        frnt,
  output logic        bck,
  output logic        lft,
  output logic        rght,
  output logic        frm_strt
);

  localparam int unsigned SPD_W   = 11;
  localparam int unsigned NCH     = 4;
  localparam int unsigned CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned PW_BASE = (CNT_W > SPD_W + SPD_SHIFT) ? CNT_W : SPD_W + SPD_SHIFT;
  localparam int unsigned PW_W    = ((PW_BASE > 20) ? PW_BASE : 20) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic [SPD_W-1:0] w_spd_in  [NCH];
  logic [SPD_W-1:0] r_shd     [NCH];
  logic [SPD_W-1:0] r_act     [NCH];
  logic [SPD_W-1:0] w_act_nxt [NCH];
  logic [PW_W-1:0]  w_pw      [NCH];
  logic [NCH-1:0]   r_pwm;
  logic             r_frm_strt;

  assign w_spd_in[0] = frnt_spd;
  assign w_spd_in[1] = bck_spd;
  assign w_spd_in[2] = lft_spd;
  assign w_spd_in[3] = rght_spd;

  assign w_load = (r_cnt == CNT_LAST);

  // Frame counter; parks on the load value in reset so the first free cycle loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= CNT_LAST;
    end else if (w_load) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef ESC_RAMP_EN
  localparam logic [SPD_W-1:0] STEP = SPD_W'((RAMP_STEP > 2047) ? 2047 : RAMP_STEP);

  // Move act toward tgt by at most STEP, landing exactly on tgt.
  function automatic logic [SPD_W-1:0] ramp_step(input logic [SPD_W-1:0] act,
                                                  input logic [SPD_W-1:0] tgt);
    logic [SPD_W-1:0] diff;
    ramp_step = tgt;
    if (tgt > act) begin
      diff = tgt - act;
      if (diff > STEP) ramp_step = act + STEP;
    end else begin
      diff = act - tgt;
      if (diff > STEP) ramp_step = act - STEP;
    end
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_act_nxt[i] = ramp_step(r_act[i], r_shd[i]);
    end
  end
`else
  logic w_unused_ramp;
  assign w_unused_ramp = (RAMP_STEP == 0);

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_act_nxt[i] = r_shd[i];
    end
  end
`endif

  // Shadows follow wrt; active speeds only change in the load cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        r_shd[i] <= '0;
        r_act[i] <= '0;
      end else begin
        if (wrt)    r_shd[i] <= w_spd_in[i];
        if (w_load) r_act[i] <= w_act_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_pw[i] = PW_W'(MIN_PULSE) + (PW_W'(r_act[i]) << SPD_SHIFT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm      <= '0;
      r_frm_strt <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_pwm[i] <= (PW_W'(r_cnt) < w_pw[i]);
      end
      r_frm_strt <= w_load;
    end
  end

  assign frnt     = r_pwm[0];
  assign bck      = r_pwm[1];
  assign lft      = r_pwm[2];
  assign rght     = r_pwm[3];
  assign frm_strt = r_frm_strt;

endmodule

// File: tb/tb_esc_pwm_quad.sv
// Scoreboard bench for esc_pwm_quad: stimulus queues expected per-frame pulse widths,
// a monitor measures each frame and compares. DUT1 uses a long frame for full-scale speed.
module tb_esc_pwm_quad;

  localparam int unsigned P0   = 1000;
  localparam int unsigned P1   = 10000;
  localparam int unsigned MINP = 100;
  localparam int unsigned SH   = 2;
  localparam int unsigned RS   = 64;

  typedef logic [3:0][15:0] exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst0, rst1, wrt0, wrt1;
  logic [3:0][10:0] spd0, spd1;
  logic [3:0]       pwm0, pwm1;
  logic             fs0, fs1;

  esc_pwm_quad #(.PERIOD(P0), .MIN_PULSE(MINP), .SPD_SHIFT(SH), .RAMP_STEP(RS)) u_dut0 (
    .clk(clk), .rst(rst0), .wrt(wrt0),
    .frnt_spd(spd0[0]), .bck_spd(spd0[1]), .lft_spd(spd0[2]), .rght_spd(spd0[3]),
    .frnt(pwm0[0]), .bck(pwm0[1]), .lft(pwm0[2]), .rght(pwm0[3]), .frm_strt(fs0)
  );

  esc_pwm_quad #(.PERIOD(P1), .MIN_PULSE(MINP), .SPD_SHIFT(SH), .RAMP_STEP(RS)) u_dut1 (
    .clk(clk), .rst(rst1), .wrt(wrt1),
    .frnt_spd(spd1[0]), .bck_spd(spd1[1]), .lft_spd(spd1[2]), .rght_spd(spd1[3]),
    .frnt(pwm1[0]), .bck(pwm1[1]), .lft(pwm1[2]), .rght(pwm1[3]), .frm_strt(fs1)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  logic [1:0] prst = 2'b11;
  always @(posedge clk) prst <= {rst1, rst0};

  // Monitor: measures high time per channel and frame length between frame starts.
  int hi [2][4];
  int flen [2];
  bit armed [2];
  always @(negedge clk) begin
    logic [3:0] pw;
    logic       fs;
    int         per;
    exp_t       e;
    bit         have;
    for (int d = 0; d < 2; d++) begin
      pw  = (d == 0) ? pwm0 : pwm1;
      fs  = (d == 0) ? fs0 : fs1;
      per = (d == 0) ? int'(P0) : int'(P1);
      if (prst[d]) begin
        checks++;
        if ({pw, fs} != 5'b0) begin
          errors++;
          $display("FAIL rst_outputs dut%0d: got pwm=%b frm_strt=%b, want 0000/0", d, pw, fs);
        end
        if (d == 0) q0.delete(); else q1.delete();
        armed[d] = 1'b0;
      end else if (fs) begin
        if (armed[d]) begin
          have = 1'b0;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL no_expectation dut%0d: frame ended with empty scoreboard", d);
          end else begin
            if (flen[d] != per) begin
              errors++;
              $display("FAIL frame_len dut%0d: got %0d, want %0d", d, flen[d], per);
            end
            for (int c = 0; c < 4; c++) begin
              checks++;
              if (hi[d][c] != int'(e[c])) begin
                errors++;
                $display("FAIL pulse_width dut%0d ch%0d: got %0d, want %0d", d, c, hi[d][c], e[c]);
              end
            end
          end
        end
        armed[d] = 1'b1;
        flen[d]  = 1;
        for (int c = 0; c < 4; c++) hi[d][c] = int'(pw[c]);
      end else begin
        flen[d]++;
        for (int c = 0; c < 4; c++) hi[d][c] += int'(pw[c]);
      end
    end
  end

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(input int d);
    bit seen = 1'b0;
    int lim = (d == 0) ? 2 * int'(P0) + 10 : 2 * int'(P1) + 10;
    for (int n = 0; n < lim && !seen; n++) begin
      @(negedge clk);
      seen = (d == 0) ? fs0 : fs1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_start_timeout dut%0d: got none in %0d cycles, want a pulse", d, lim);
    end
  endtask

  task automatic push(input int d, input int f, input int b, input int l, input int r);
    exp_t e;
    e[0] = 16'(f); e[1] = 16'(b); e[2] = 16'(l); e[3] = 16'(r);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic write(input int d, input int f, input int b, input int l, input int r);
    if (d == 0) begin
      spd0[0] = 11'(f); spd0[1] = 11'(b); spd0[2] = 11'(l); spd0[3] = 11'(r); wrt0 = 1'b1;
    end else begin
      spd1[0] = 11'(f); spd1[1] = 11'(b); spd1[2] = 11'(l); spd1[3] = 11'(r); wrt1 = 1'b1;
    end
    @(negedge clk);
    wrt0 = 1'b0;
    wrt1 = 1'b0;
  endtask

  initial begin
    int up [4];
    int dn [4];
    int big [4];
`ifdef ESC_RAMP_EN
    up  = '{356, 612, 868, 900};
    dn  = '{644, 388, 132, 100};
    big = '{140, 100, 356, 356};
`else
    up  = '{900, 900, 900, 900};
    dn  = '{100, 100, 100, 100};
    big = '{140, 100, 8288, 500};
`endif
    rst0 = 1'b1; rst1 = 1'b1; wrt0 = 1'b0; wrt1 = 1'b0;
    spd0 = '0;   spd1 = '0;
    skip(4);
    rst0 = 1'b0;

    // Idle frames after reset release
    wait_fs(0); push(0, 100, 100, 100, 100);
    wait_fs(0); push(0, 100, 100, 100, 100);
    skip(300);  write(0, 20, 0, 0, 0);
    wait_fs(0); push(0, 180, 100, 100, 100);
    // Write lands exactly in the load cycle: old shadow loads, new one waits a frame
    skip(int'(P0) - 1); write(0, 50, 0, 0, 0);
    push(0, 180, 100, 100, 100);
    wait_fs(0); push(0, 300, 100, 100, 100);
    // Reset mid-pulse discards the frame and the pending shadows
    skip(150); rst0 = 1'b1; skip(1); rst0 = 1'b0;
    wait_fs(0); push(0, 100, 100, 100, 100);
    wait_fs(0); push(0, 100, 100, 100, 100);
    skip(300);  write(0, 200, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      wait_fs(0); push(0, up[k], 100, 100, 100);
    end
    skip(300);  write(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      wait_fs(0); push(0, dn[k], 100, 100, 100);
    end
    wait_fs(0);
    rst0 = 1'b1;

    // Full-scale speed on the long-frame instance
    rst1 = 1'b0;
    wait_fs(1); push(1, 100, 100, 100, 100);
    skip(3000); write(1, 10, 0, 2047, 100);
    wait_fs(1); push(1, big[0], big[1], big[2], big[3]);
    wait_fs(1);
    skip(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout at %0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
